// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and
// the valid/ready handshake towards decode.
interface ifu_fetch_if #(
    parameter int RegWidth = 64,
    parameter int INSTWide = 32
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [RegWidth-1:0] imem_addr;
    logic                imem_resp_valid;
    logic [INSTWide-1:0] imem_resp_data;
    logic                redirect_valid;
    logic [RegWidth-1:0] redirect_pc;
    logic [INSTWide-1:0] id_inst;
    logic [RegWidth-1:0] id_pc;
    logic                ifu_valid;
    logic                idu_ready;

    modport master (
        output imem_req_valid,
        output imem_addr,
        output id_inst,
        output id_pc,
        output ifu_valid,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        input  idu_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        input  id_inst,
        input  id_pc,
        input  ifu_valid,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        output idu_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding 32-bit read, redirect with
// stale-response drop, and a held {inst, pc} slot towards decode.
module ifu_fetch #(
    parameter int                  RegWidth = 64,
    parameter int                  INSTWide = 32,
    parameter logic [RegWidth-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       rst,
    ifu_fetch_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [RegWidth-1:0] ALIGN = ~RegWidth'(3);
    localparam logic [INSTWide-1:0] NOP   = INSTWide'(32'h0000_0013);

    state_t              state_q, state_d;
    logic [RegWidth-1:0] pc_q, pc_d;
    logic                drop_q, drop_d;
    logic                valid_q, valid_d;
    logic [INSTWide-1:0] inst_q, inst_d;
    logic [RegWidth-1:0] idpc_q, idpc_d;
    logic [RegWidth-1:0] redir_pc;

    assign redir_pc = bus.redirect_pc & ALIGN;

    // State and datapath registers, async reset to the boot fetch state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            valid_q <= 1'b0;
            inst_q  <= NOP;
            idpc_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            idpc_q  <= idpc_d;
        end
    end

    // Next-state logic; a redirect overrides every other event
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        idpc_d  = idpc_q;
        if (bus.redirect_valid) begin
            pc_d = redir_pc;
            unique case (state_q)
                S_REQ: begin
                    if (bus.imem_req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                S_HOLD: begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (bus.imem_req_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_d  = bus.imem_resp_data;
                            idpc_d  = pc_q;
                            valid_d = 1'b1;
                            pc_d    = pc_q + RegWidth'(4);
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.idu_ready) begin
                        valid_d = 1'b0;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Outputs come only from registered state
    always_comb begin
        bus.imem_req_valid = (state_q == S_REQ);
        bus.imem_addr      = pc_q & ALIGN;
        bus.ifu_valid      = valid_q;
        bus.id_inst        = inst_q;
        bus.id_pc          = idpc_q;
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed-vector bench for ifu_fetch: per-cycle inputs and expected
// outputs, plus hand sequences for asynchronous reset mid-cycle.
module tb_ifu_fetch;

    localparam logic [63:0] B   = 64'h8000_0000;
    localparam logic [63:0] W   = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I1  = 32'h0010_0093;
    localparam logic [31:0] I2  = 32'h0020_0113;
    localparam logic [31:0] I3  = 32'h0030_0193;
    localparam logic [31:0] I4  = 32'h0040_0213;
    localparam logic [31:0] I5  = 32'h0050_0293;
    localparam logic [31:0] I6  = 32'h0060_0313;

    typedef struct {
        logic        rst;
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        rdv;
        logic [63:0] rpc;
        logic        idu;
        logic        e_rqv;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_pc;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ifu_fetch_if #(.RegWidth(64), .INSTWide(32)) bus ();

    ifu_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rs, input logic rr, input logic rv,
        input logic [31:0] rd, input logic rdv, input logic [63:0] rpc,
        input logic idu, input logic e_rqv, input logic [63:0] e_addr,
        input logic e_iv, input logic [31:0] e_inst, input logic [63:0] e_pc
    );
        vec_t v;
        v.rst = rs; v.rr = rr; v.rv = rv; v.rd = rd;
        v.rdv = rdv; v.rpc = rpc; v.idu = idu;
        v.e_rqv = e_rqv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(
        input string tag, input logic e_rqv, input logic [63:0] e_addr,
        input logic e_iv, input logic [31:0] e_inst, input logic [63:0] e_pc
    );
        n_cmp++;
        if (bus.imem_req_valid !== e_rqv || bus.imem_addr !== e_addr ||
            bus.ifu_valid !== e_iv || bus.id_inst !== e_inst ||
            bus.id_pc !== e_pc) begin
            n_err++;
            $display("FAIL %s: got rqv=%0b addr=%h iv=%0b inst=%h pc=%h, want rqv=%0b addr=%h iv=%0b inst=%h pc=%h",
                     tag, bus.imem_req_valid, bus.imem_addr, bus.ifu_valid,
                     bus.id_inst, bus.id_pc, e_rqv, e_addr, e_iv, e_inst, e_pc);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        check(tag, v.e_rqv, v.e_addr, v.e_iv, v.e_inst, v.e_pc);
        rst                 = v.rst;
        bus.imem_req_ready  = v.rr;
        bus.imem_resp_valid = v.rv;
        bus.imem_resp_data  = v.rd;
        bus.redirect_valid  = v.rdv;
        bus.redirect_pc     = v.rpc;
        bus.idu_ready       = v.idu;
    endtask

    vec_t t1[$];
    vec_t t2[$];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.idu_ready       = 1'b0;

        // reset, first fetch, second request
        t1.push_back(mk(1,1,1,32'h0,0,0,1, 1,B,0,NOP,0));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 1,B,0,NOP,0));
        t1.push_back(mk(0,1,1,I1,0,0,1, 0,B,0,NOP,0));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 0,B+4,1,I1,B));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 1,B+4,0,I1,B));
        t1.push_back(mk(0,1,1,I2,0,0,1, 0,B+4,0,I1,B));
        // backpressure in HOLD
        for (int i = 0; i < 5; i++)
            t1.push_back(mk(0,1,0,32'h0,0,0,0, 0,B+8,1,I2,B+4));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 0,B+8,1,I2,B+4));
        t1.push_back(mk(0,0,0,32'h0,0,0,1, 1,B+8,0,I2,B+4));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 1,B+8,0,I2,B+4));
        // redirect while waiting, stale response dropped
        t1.push_back(mk(0,1,0,32'h0,1,B+64'h100,1, 0,B+8,0,I2,B+4));
        t1.push_back(mk(0,1,1,32'hDEAD_BEEF,0,0,1, 0,B+64'h100,0,I2,B+4));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 1,B+64'h100,0,I2,B+4));
        t1.push_back(mk(0,1,1,I3,0,0,1, 0,B+64'h100,0,I2,B+4));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 0,B+64'h104,1,I3,B+64'h100));
        // redirect together with the response, unaligned target
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 1,B+64'h104,0,I3,B+64'h100));
        t1.push_back(mk(0,1,1,32'hCAFE_F00D,1,B+64'h203,1, 0,B+64'h104,0,I3,B+64'h100));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 1,B+64'h200,0,I3,B+64'h100));
        t1.push_back(mk(0,1,1,I4,0,0,1, 0,B+64'h200,0,I3,B+64'h100));
        // redirect in HOLD with decode ready
        t1.push_back(mk(0,1,0,32'h0,1,B+64'h400,1, 0,B+64'h204,1,I4,B+64'h200));
        t1.push_back(mk(0,0,0,32'h0,0,0,1, 1,B+64'h400,0,I4,B+64'h200));
        // redirect while the request is accepted
        t1.push_back(mk(0,1,0,32'h0,1,B+64'h500,1, 1,B+64'h400,0,I4,B+64'h200));
        t1.push_back(mk(0,1,1,32'h1111_1111,0,0,1, 0,B+64'h500,0,I4,B+64'h200));
        // wrap of pc+4
        t1.push_back(mk(0,0,0,32'h0,1,W,1, 1,B+64'h500,0,I4,B+64'h200));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 1,W,0,I4,B+64'h200));
        t1.push_back(mk(0,1,1,I5,0,0,1, 0,W,0,I4,B+64'h200));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 0,64'h0,1,I5,W));
        t1.push_back(mk(0,1,0,32'h0,0,0,1, 1,64'h0,0,I5,W));
        t1.push_back(mk(0,1,1,I6,0,0,0, 0,64'h0,0,I5,W));
        t1.push_back(mk(0,0,0,32'h0,0,0,0, 0,64'h4,1,I6,64'h0));

        for (int i = 0; i < t1.size(); i++)
            apply(t1[i], $sformatf("t1_%0d", i));

        // async reset while HOLD: valid drops immediately
        @(negedge clk);
        check("hold_pre_rst", 1'b0, 64'h4, 1'b1, I6, 64'h0);
        #2 rst = 1'b1;
        #1 check("hold_async_rst", 1'b1, B, 1'b0, NOP, 64'h0);

        t2.push_back(mk(1,1,0,32'h0,0,0,1, 1,B,0,NOP,0));
        t2.push_back(mk(0,1,0,32'h0,0,0,1, 1,B,0,NOP,0));
        t2.push_back(mk(0,0,0,32'h0,0,0,1, 0,B,0,NOP,0));
        for (int i = 0; i < t2.size(); i++)
            apply(t2[i], $sformatf("t2_%0d", i));

        // async reset while WAIT, then a late response is ignored
        @(negedge clk);
        check("wait_pre_rst", 1'b0, B, 1'b0, NOP, 64'h0);
        #2 rst = 1'b1;
        #1 check("wait_async_rst", 1'b1, B, 1'b0, NOP, 64'h0);

        t2.delete();
        t2.push_back(mk(1,0,0,32'h0,0,0,1, 1,B,0,NOP,0));
        t2.push_back(mk(0,0,1,32'hBADB_AD00,0,0,1, 1,B,0,NOP,0));
        t2.push_back(mk(0,1,0,32'h0,0,0,1, 1,B,0,NOP,0));
        t2.push_back(mk(0,1,1,I1,0,0,1, 0,B,0,NOP,0));
        t2.push_back(mk(0,1,0,32'h0,0,0,1, 0,B+4,1,I1,B));
        t2.push_back(mk(0,0,0,32'h0,0,0,0, 1,B+4,0,I1,B));
        for (int i = 0; i < t2.size(); i++)
            apply(t2[i], $sformatf("t3_%0d", i));

        @(negedge clk);
        check("final", 1'b1, B+4, 1'b0, I1, B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
